// File: rtl/rx_parity_checker.sv
// rx_parity_checker
//
// Receive-side parity checker that runs beside the RX core FSM. While the core is in
// DATABITS it XORs each mid-bit sample into a running accumulator. On the first sample
// in PARITYBIT it compares the received bit against the expected parity. It then reports
// a check-done pulse, a parity-error pulse and a sticky error flag.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-low reset
//   State_i[4:0]        RX FSM one-hot state (INTERVAL, STARTBIT, DATABITS, PARITYBIT, STOPBIT)
//   p_BitSample_i       one-cycle strobe: RxBit_i is a valid mid-bit sample
//   RxBit_i             sampled line value
//   ParityEnable_i      1 = check parity, 0 = accumulate only
//   ParityMethod_i      0 = even, 1 = odd
//   p_ErrorClear_i      one-cycle pulse clearing the sticky flag
//   ParityResult_o      expected parity for bits accumulated so far (registered)
//   p_CheckDone_o       one-cycle pulse after the parity sample is processed
//   p_ParityError_o     one-cycle pulse on parity mismatch
//   ParityErrorFlag_o   sticky mismatch flag

module rx_parity_checker #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] State_i,
  input  logic       p_BitSample_i,
  input  logic       RxBit_i,
  input  logic       ParityEnable_i,
  input  logic       ParityMethod_i,
  input  logic       p_ErrorClear_i,
  output logic       ParityResult_o,
  output logic       p_CheckDone_o,
  output logic       p_ParityError_o,
  output logic       ParityErrorFlag_o
);

  localparam logic [4:0] StDataBits  = 5'b00100;
  localparam logic [4:0] StParityBit = 5'b01000;
  localparam logic [4:0] StStopBit   = 5'b10000;

  localparam logic [3:0] CntMax = 4'(DATA_WIDTH);

  logic       acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       checked_q, checked_d;
  logic       result_q, result_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       flag_q, flag_d;
  logic       exp_bit;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    checked_d = checked_q;
    result_d  = 1'b1;
    done_d    = 1'b0;
    err_d     = 1'b0;
    exp_bit   = acc_q ^ ParityMethod_i;

    case (State_i)
      StDataBits: begin
        // Samples beyond DATA_WIDTH are dropped; the counter saturates.
        if (p_BitSample_i && (cnt_q < CntMax)) begin
          acc_d = acc_q ^ RxBit_i;
          cnt_d = cnt_q + 4'd1;
        end
        result_d = acc_d ^ ParityMethod_i;
      end
      StParityBit: begin
        // Only the first strobe of the frame is checked.
        if (p_BitSample_i && !checked_q) begin
          checked_d = 1'b1;
          done_d    = 1'b1;
          err_d     = ParityEnable_i && (RxBit_i != exp_bit);
        end
        result_d = acc_q ^ ParityMethod_i;
      end
      StStopBit: begin
        result_d = acc_q ^ ParityMethod_i;
      end
      default: begin
        // INTERVAL, STARTBIT and any non-one-hot encoding start a fresh frame.
        acc_d     = 1'b0;
        cnt_d     = 4'd0;
        checked_d = 1'b0;
        result_d  = 1'b1;
      end
    endcase

    // A new mismatch wins over a simultaneous clear.
    if (err_d) begin
      flag_d = 1'b1;
    end else if (p_ErrorClear_i) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= 1'b0;
      cnt_q     <= 4'd0;
      checked_q <= 1'b0;
      result_q  <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      checked_q <= checked_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
      flag_q    <= flag_d;
    end
  end

  assign ParityResult_o    = result_q;
  assign p_CheckDone_o     = done_q;
  assign p_ParityError_o   = err_q;
  assign ParityErrorFlag_o = flag_q;

endmodule

// File: tb/tb_rx_parity_checker.sv
// tb_rx_parity_checker
//
// Self-checking bench for rx_parity_checker. Each parity strobe pushes the expected
// error/flag outcome to a scoreboard queue; the scenario task pops and compares it when
// the check-done pulse is due.

module tb_rx_parity_checker;

  localparam int unsigned DW = 8;
  localparam logic [4:0] S_INT   = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_DATA  = 5'b00100;
  localparam logic [4:0] S_PAR   = 5'b01000;
  localparam logic [4:0] S_STOP  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] State_i = S_INT;
  logic       p_BitSample_i = 1'b0;
  logic       RxBit_i = 1'b1;
  logic       ParityEnable_i = 1'b1;
  logic       ParityMethod_i = 1'b0;
  logic       p_ErrorClear_i = 1'b0;
  logic       ParityResult_o;
  logic       p_CheckDone_o;
  logic       p_ParityError_o;
  logic       ParityErrorFlag_o;

  always #5 clk = ~clk;

  rx_parity_checker #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .State_i          (State_i),
    .p_BitSample_i    (p_BitSample_i),
    .RxBit_i          (RxBit_i),
    .ParityEnable_i   (ParityEnable_i),
    .ParityMethod_i   (ParityMethod_i),
    .p_ErrorClear_i   (p_ErrorClear_i),
    .ParityResult_o   (ParityResult_o),
    .p_CheckDone_o    (p_CheckDone_o),
    .p_ParityError_o  (p_ParityError_o),
    .ParityErrorFlag_o(ParityErrorFlag_o)
  );

  typedef struct packed {
    logic err;
    logic flag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass = 0;
  logic model_acc = 1'b0;
  int   model_cnt = 0;
  logic model_flag = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    State_i = S_INT;
    tick();
    State_i = S_START;
    tick();
    model_acc = 1'b0;
    model_cnt = 0;
  endtask

  // Back-to-back strobes, LSB first; model saturates at DW bits.
  task automatic drive_data(input logic [8:0] bits, input int n);
    State_i = S_DATA;
    for (int i = 0; i < n; i++) begin
      p_BitSample_i = 1'b1;
      RxBit_i = bits[i];
      tick();
      if (model_cnt < DW) begin
        model_acc = model_acc ^ bits[i];
        model_cnt++;
      end
    end
    p_BitSample_i = 1'b0;
    RxBit_i = 1'b1;
  endtask

  // Enter PARITYBIT, strobe once and return where the done pulse should be visible.
  task automatic drive_parity(input logic b, input logic clr);
    exp_t x;
    State_i = S_PAR;
    tick();
    p_BitSample_i = 1'b1;
    RxBit_i = b;
    p_ErrorClear_i = clr;
    x.err = ParityEnable_i && (b != (model_acc ^ ParityMethod_i));
    if (x.err) model_flag = 1'b1;
    else if (clr) model_flag = 1'b0;
    x.flag = model_flag;
    sb.push_back(x);
    tick();
    p_BitSample_i = 1'b0;
    p_ErrorClear_i = 1'b0;
    RxBit_i = 1'b1;
  endtask

  task automatic end_frame();
    State_i = S_STOP;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++; if (ParityResult_o !== 1'b1) $display("FAIL reset_result: got %b want 1", ParityResult_o); else n_pass++;
    n_checks++; if (p_CheckDone_o !== 1'b0) $display("FAIL reset_done: got %b want 0", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== 1'b0) $display("FAIL reset_err: got %b want 0", p_ParityError_o); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== 1'b0) $display("FAIL reset_flag: got %b want 0", ParityErrorFlag_o); else n_pass++;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_even_pass();
    ParityEnable_i = 1'b1;
    ParityMethod_i = 1'b0;
    start_frame();
    drive_data(9'h0A5, 8);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL even_pass_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    drive_parity(1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_CheckDone_o !== 1'b1) $display("FAIL even_pass_done: got %b want 1", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL even_pass_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== e.flag) $display("FAIL even_pass_flag: got %b want %b", ParityErrorFlag_o, e.flag); else n_pass++;
    tick();
    n_checks++; if (p_CheckDone_o !== 1'b0) $display("FAIL even_pass_done_width: got %b want 0", p_CheckDone_o); else n_pass++;
    end_frame();
  endtask

  task automatic test_even_error();
    start_frame();
    drive_data(9'h0A5, 8);
    drive_parity(1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_CheckDone_o !== 1'b1) $display("FAIL even_err_done: got %b want 1", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL even_err_pulse: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== e.flag) $display("FAIL even_err_flag: got %b want %b", ParityErrorFlag_o, e.flag); else n_pass++;
    tick();
    n_checks++; if (p_ParityError_o !== 1'b0) $display("FAIL even_err_pulse_width: got %b want 0", p_ParityError_o); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== model_flag) $display("FAIL even_err_flag_hold: got %b want %b", ParityErrorFlag_o, model_flag); else n_pass++;
    end_frame();
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL stop_hold_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    // Clean frame: flag must persist.
    start_frame();
    drive_data(9'h000, 8);
    drive_parity(1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL clean_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== e.flag) $display("FAIL clean_flag_sticky: got %b want %b", ParityErrorFlag_o, e.flag); else n_pass++;
    end_frame();
  endtask

  task automatic test_odd();
    ParityMethod_i = 1'b1;
    start_frame();
    drive_data(9'h001, 8);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL odd_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    drive_parity(1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL odd_pass_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    end_frame();
    start_frame();
    drive_data(9'h001, 8);
    drive_parity(1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL odd_fail_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    end_frame();
    p_ErrorClear_i = 1'b1;
    tick();
    p_ErrorClear_i = 1'b0;
    model_flag = 1'b0;
    n_checks++; if (ParityErrorFlag_o !== model_flag) $display("FAIL clear_flag: got %b want %b", ParityErrorFlag_o, model_flag); else n_pass++;
    // Clear coincident with a mismatch: set wins.
    start_frame();
    drive_data(9'h001, 8);
    drive_parity(1'b1, 1'b1);
    e = sb.pop_front();
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL clear_vs_err_pulse: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== e.flag) $display("FAIL clear_vs_err_flag: got %b want %b", ParityErrorFlag_o, e.flag); else n_pass++;
    end_frame();
    ParityMethod_i = 1'b0;
  endtask

  task automatic test_disabled();
    ParityEnable_i = 1'b0;
    start_frame();
    drive_data(9'h0FF, 8);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL dis_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    drive_parity(1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_CheckDone_o !== 1'b1) $display("FAIL dis_done: got %b want 1", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL dis_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== e.flag) $display("FAIL dis_flag: got %b want %b", ParityErrorFlag_o, e.flag); else n_pass++;
    // Second strobe in the same PARITYBIT is ignored.
    p_BitSample_i = 1'b1;
    RxBit_i = 1'b1;
    tick();
    p_BitSample_i = 1'b0;
    n_checks++; if (p_CheckDone_o !== 1'b0) $display("FAIL dis_second_done: got %b want 0", p_CheckDone_o); else n_pass++;
    end_frame();
    ParityEnable_i = 1'b1;
  endtask

  task automatic test_saturate();
    start_frame();
    drive_data(9'h100, 9);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL sat_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    drive_parity(1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL sat_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    end_frame();
  endtask

  task automatic test_short_frame();
    start_frame();
    drive_data(9'h007, 3);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL short_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    drive_parity(1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_CheckDone_o !== 1'b1) $display("FAIL short_done: got %b want 1", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL short_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    end_frame();
  endtask

  task automatic test_illegal_state();
    start_frame();
    drive_data(9'h001, 1);
    State_i = 5'b00110;
    tick();
    n_checks++; if (ParityResult_o !== 1'b1) $display("FAIL illegal_result: got %b want 1", ParityResult_o); else n_pass++;
    model_acc = 1'b0;
    model_cnt = 0;
    drive_data(9'h000, 1);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL illegal_acc_clear: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    end_frame();
  endtask

  task automatic test_reset_mid();
    start_frame();
    drive_data(9'h00F, 4);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL rstmid_pre_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    #2 rst = 1'b0;
    #1;
    model_flag = 1'b0;
    n_checks++; if (ParityResult_o !== 1'b1) $display("FAIL rstmid_result: got %b want 1", ParityResult_o); else n_pass++;
    n_checks++; if (p_CheckDone_o !== 1'b0) $display("FAIL rstmid_done: got %b want 0", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== 1'b0) $display("FAIL rstmid_err: got %b want 0", p_ParityError_o); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== 1'b0) $display("FAIL rstmid_flag: got %b want 0", ParityErrorFlag_o); else n_pass++;
    tick();
    rst = 1'b1;
    start_frame();
    drive_data(9'h003, 8);
    drive_parity(1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_CheckDone_o !== 1'b1) $display("FAIL rstmid_next_done: got %b want 1", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL rstmid_next_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    n_checks++; if (ParityErrorFlag_o !== e.flag) $display("FAIL rstmid_next_flag: got %b want %b", ParityErrorFlag_o, e.flag); else n_pass++;
    end_frame();
  endtask

  task automatic test_back_to_back();
    start_frame();
    drive_data(9'h001, 8);
    drive_parity(1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL b2b_first_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    end_frame();
    // STOPBIT straight into STARTBIT.
    State_i = S_START;
    tick();
    model_acc = 1'b0;
    model_cnt = 0;
    drive_data(9'h000, 8);
    n_checks++; if (ParityResult_o !== (model_acc ^ ParityMethod_i)) $display("FAIL b2b_result: got %b want %b", ParityResult_o, model_acc ^ ParityMethod_i); else n_pass++;
    drive_parity(1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (p_CheckDone_o !== 1'b1) $display("FAIL b2b_done: got %b want 1", p_CheckDone_o); else n_pass++;
    n_checks++; if (p_ParityError_o !== e.err) $display("FAIL b2b_err: got %b want %b", p_ParityError_o, e.err); else n_pass++;
    end_frame();
    State_i = S_INT;
    tick();
  endtask

  initial begin
    test_reset();
    test_even_pass();
    test_even_error();
    test_odd();
    test_disabled();
    test_saturate();
    test_short_frame();
    test_illegal_state();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/rx_parity_checker.md
Name: rx_parity_checker

Overview:
Receive-side counterpart of the TX parity generator. It accumulates parity serially over data bits as the RX core samples them, then compares the received parity bit against the expected value. It reports a per-frame check-done pulse, a one-cycle parity-error pulse and a sticky error flag for the status path. It sits beside the RX core FSM, driven by the RX state vector and the mid-bit sample strobe.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..8); bits sampled beyond this count are ignored.

Ports:
clk  input  1  system clock (>=40 MHz)
rst  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk
State_i  input  5  RX FSM one-hot state: INTERVAL=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000
p_BitSample_i  input  1  one-cycle pulse: RxBit_i is a valid mid-bit sample this cycle
RxBit_i  input  1  sampled line value
ParityEnable_i  input  1  1 = perform the check; 0 = accumulate only, never flag an error
ParityMethod_i  input  1  0 = even, 1 = odd
p_ErrorClear_i  input  1  one-cycle pulse that clears the sticky flag
ParityResult_o  output  1  expected parity bit for the bits accumulated so far (registered)
p_CheckDone_o  output  1  one-cycle pulse after the parity bit sample is processed
p_ParityError_o  output  1  one-cycle pulse on parity mismatch
ParityErrorFlag_o  output  1  sticky mismatch flag

Behaviour:
- Reset values: acc_r=0, bit_cnt_r=0, checked_r=0, ParityResult_o=1, p_CheckDone_o=0, p_ParityError_o=0, ParityErrorFlag_o=0. A reset mid-frame aborts the frame; no pulses are produced.
- Internal state: acc_r (running XOR); bit_cnt_r (4 bit, saturates at DATA_WIDTH); checked_r (one check per frame).
- INTERVAL or STARTBIT, and any non-one-hot or illegal State_i: clear acc_r, bit_cnt_r and checked_r. ParityResult_o=1.
- DATABITS, on p_BitSample_i and bit_cnt_r<DATA_WIDTH: acc_r<=acc_r^RxBit_i and bit_cnt_r+1.
- DATABITS, on p_BitSample_i and bit_cnt_r==DATA_WIDTH: the sample is ignored and no state changes.
- ParityResult_o in DATABITS, PARITYBIT and STOPBIT is acc_next^ParityMethod_i, registered. It reflects a sample taken in cycle N at cycle N+1. Even: XOR of the data bits. Odd: its inverse.
- PARITYBIT, on the first p_BitSample_i while checked_r=0:
  - expected = acc_r^ParityMethod_i; set checked_r.
  - Next cycle: p_CheckDone_o=1.
  - If ParityEnable_i=1 and RxBit_i!=expected: in the same next cycle p_ParityError_o=1 and ParityErrorFlag_o<=1.
  - ParityMethod_i and ParityEnable_i are sampled at this strobe.
- Further strobes in PARITYBIT, or any strobe in STOPBIT, are ignored.
- STOPBIT: acc_r, bit_cnt_r and ParityResult_o are held.
- The transition STOPBIT->STARTBIT (back-to-back frames) clears the accumulator per the rule above. No state is carried across frames except ParityErrorFlag_o.
- Frame with parity disabled: the FSM skips PARITYBIT, so no check, no pulses and the flag is unchanged. If PARITYBIT is entered with ParityEnable_i=0, p_CheckDone_o still pulses and no error is raised.
- ParityErrorFlag_o: set by a mismatch and cleared by p_ErrorClear_i. If both occur in the same cycle, set wins.
- Short frame (fewer than DATA_WIDTH samples before PARITYBIT): the check runs on the bits received; no separate error is raised.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Even, enable=1, data 0xA5 (LSB first), parity sample 0 -> ParityResult_o=0 after the 8th sample, p_CheckDone_o pulses 1 cycle after the parity strobe, no error, flag=0.
- Even, data 0xA5, parity sample 1 -> p_ParityError_o 1-cycle pulse coincident with p_CheckDone_o, flag=1 and it persists through the next clean frame (0x00, parity 0).
- Odd, data 0x01, parity 0 -> no error; same frame with parity 1 -> error. Then p_ErrorClear_i -> flag=0 next cycle. Clear and error asserted in the same cycle -> flag stays 1.
- Enable=0, data 0xFF, parity sample 1 -> p_CheckDone_o pulses, p_ParityError_o=0, flag unchanged. A second parity strobe in the same PARITYBIT -> no second done pulse.
- 9 strobes in DATABITS with data 0x00 and the 9th bit=1, even -> the 9th is ignored, ParityResult_o=0, parity 0 gives no error.
- rst low mid-DATABITS after 4 bits of 0x0F -> all outputs return to reset values immediately. The next frame 0x03 with even parity 0 passes with no error.
